hc_sr04_range_filter: RTL and testbench

HC_SR04_RANGE_FILTER -- requirements
Module: hc_sr04_range_filter

---
 rtl/hc_sr04_range_filter.sv | 204 ++++++++++++++++++++
 tb/tb_hc_sr04_range_filter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_range_filter.sv
// hc_sr04_range_filter
//
// Converts HC-SR04 echo high-time (in clk ticks) to centimetres, saturates
// the result, and smooths it with a power-of-two moving average. It also
// raises an obstacle flag with hysteresis and a timeout fault when samples
// stop arriving.
//
// Optional build macro: HC_SR04_MEDIAN3_EN inserts a 3-tap median stage ahead
// of the moving average. This adds one cycle of latency, for 4 in total. The
// default build has no median stage and 3 cycles of latency.
//
// Ports:
//   clk        system clock (CLK_FREQ Hz)
//   reset      synchronous, active-high
//   in_valid   single-cycle strobe qualifying in_ticks
//   in_ticks   echo high time in clk cycles (IN_WL bits)
//   out_valid  single-cycle strobe qualifying raw_cm / avg_cm
//   raw_cm     unfiltered, saturated distance of the latest sample
//   avg_cm     moving average over 2^AVG_LOG2 samples (truncating)
//   near       obstacle flag, set below NEAR_CM, cleared at NEAR_CM+HYST_CM
//   fault      no in_valid seen for TIMEOUT_MS milliseconds
module hc_sr04_range_filter #(
  parameter int CLK_FREQ   = 100000000,
  parameter int IN_WL      = 32,
  parameter int DIST_WL    = 10,
  parameter int MAX_CM     = 400,
  parameter int AVG_LOG2   = 2,
  parameter int NEAR_CM    = 30,
  parameter int HYST_CM    = 5,
  parameter int TIMEOUT_MS = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IN_WL-1:0]   in_ticks,
  output logic               out_valid,
  output logic [DIST_WL-1:0] raw_cm,
  output logic [DIST_WL-1:0] avg_cm,
  output logic               near,
  output logic               fault
);

  // cm = ticks * 17150 / CLK_FREQ, carried as a Q24 fixed-point multiplier.
  localparam longint unsigned SCALE_NUM = 64'd17150 << 24;
  localparam longint unsigned SCALE_K_L = (SCALE_NUM + 64'(CLK_FREQ) / 64'd2) / 64'(CLK_FREQ);
  localparam int              K_W       = $clog2(SCALE_K_L + 64'd1);
  localparam logic [K_W-1:0]  SCALE_K   = K_W'(SCALE_K_L);
  localparam int              PROD_W    = IN_WL + K_W;
  localparam int              SH_W      = PROD_W - 24;
  localparam int              SUM_W     = DIST_WL + AVG_LOG2;
  localparam int              DEPTH     = 1 << AVG_LOG2;

  localparam longint unsigned  TIMEOUT_L = 64'(TIMEOUT_MS) * 64'(CLK_FREQ) / 64'd1000;
  localparam int               GAP_W     = $clog2(TIMEOUT_L + 64'd1);
  localparam logic [GAP_W-1:0] TIMEOUT   = GAP_W'(TIMEOUT_L);

  localparam logic [DIST_WL-1:0] NEAR_SET = DIST_WL'(NEAR_CM);
  localparam logic [DIST_WL-1:0] NEAR_CLR = DIST_WL'(NEAR_CM + HYST_CM);

  function automatic logic [DIST_WL-1:0] sat_cm(input logic [PROD_W-1:0] prod);
    logic [SH_W-1:0] whole;
    whole = prod[PROD_W-1:24];
    if (whole > SH_W'(MAX_CM)) sat_cm = DIST_WL'(MAX_CM);
    else                       sat_cm = DIST_WL'(whole);
  endfunction

  // ---- stage 1: full-width product ----
  logic              vld_p1;
  logic [PROD_W-1:0] prod_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) prod_p1 <= PROD_W'(in_ticks) * PROD_W'(SCALE_K);
  end

  // ---- stage 2: scale down and saturate ----
  logic               vld_p2;
  logic [DIST_WL-1:0] cm_p2;

  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) cm_p2 <= sat_cm(prod_p1);
  end

  // Inputs to the averaging stage: either straight from stage 2 or via the median.
  logic               acc_vld;
  logic [DIST_WL-1:0] acc_cm;
  logic [DIST_WL-1:0] acc_raw;

`ifdef HC_SR04_MEDIAN3_EN
  function automatic logic [DIST_WL-1:0] med3(input logic [DIST_WL-1:0] a,
                                               input logic [DIST_WL-1:0] b,
                                               input logic [DIST_WL-1:0] c);
    logic [DIST_WL-1:0] lo;
    logic [DIST_WL-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      med3 = lo;
    else if (c > hi) med3 = hi;
    else             med3 = c;
  endfunction

  // ---- stage 3 (median build): median of the current and two previous cm ----
  logic               vld_p3;
  logic [DIST_WL-1:0] raw_p3;
  logic [DIST_WL-1:0] med_p3;
  logic [DIST_WL-1:0] tap1;
  logic [DIST_WL-1:0] tap2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p3 <= 1'b0;
      tap1   <= '0;
      tap2   <= '0;
    end else begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        tap1 <= cm_p2;
        tap2 <= tap1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p2) begin
      raw_p3 <= cm_p2;
      med_p3 <= med3(cm_p2, tap1, tap2);
    end
  end

  assign acc_vld = vld_p3;
  assign acc_cm  = med_p3;
  assign acc_raw = raw_p3;
`else
  assign acc_vld = vld_p2;
  assign acc_cm  = cm_p2;
  assign acc_raw = cm_p2;
`endif

  // ---- final stage: ring buffer, running sum, outputs ----
  logic [DIST_WL-1:0]  ring [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    new_sum;
  logic [DIST_WL-1:0]  new_avg;

  // The entry at wr_ptr is the oldest sample; it leaves the sum as acc_cm enters.
  always_comb begin
    new_sum = sum - SUM_W'(ring[wr_ptr]) + SUM_W'(acc_cm);
    new_avg = DIST_WL'(new_sum >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      raw_cm    <= '0;
      avg_cm    <= '0;
      near      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= acc_vld;
      if (acc_vld) begin
        ring[wr_ptr] <= acc_cm;
        wr_ptr       <= wr_ptr + AVG_LOG2'(1);
        sum          <= new_sum;
        raw_cm       <= acc_raw;
        avg_cm       <= new_avg;
        if (new_avg < NEAR_SET)       near <= 1'b1;
        else if (new_avg >= NEAR_CLR) near <= 1'b0;
      end
    end
  end

  // Gap counter: saturates at TIMEOUT so fault holds until the next sample.
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;

  always_comb begin
    gap_next = gap_cnt;
    if (in_valid)                gap_next = '0;
    else if (gap_cnt != TIMEOUT) gap_next = gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      gap_cnt <= gap_next;
      fault   <= !in_valid && (gap_next == TIMEOUT);
    end
  end

endmodule

// File: tb/tb_hc_sr04_range_filter.sv
module tb_hc_sr04_range_filter;

`ifdef HC_SR04_MEDIAN3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int K      = 2877;   // scale factor at 100 MHz
  localparam int TO_CYC = 2000;   // timeout of the small instance: 2 ms at 1 MHz

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_ticks = '0;
  logic        out_valid;
  logic [9:0]  raw_cm;
  logic [9:0]  avg_cm;
  logic        near;
  logic        fault;

  logic        t_valid = 1'b0;
  logic        t_out_valid;
  logic [9:0]  t_raw;
  logic [9:0]  t_avg;
  logic        t_near;
  logic        t_fault;

  hc_sr04_range_filter u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ticks(in_ticks),
    .out_valid(out_valid), .raw_cm(raw_cm), .avg_cm(avg_cm), .near(near), .fault(fault)
  );

  // Second instance with a short timeout so the fault path fits a short run.
  hc_sr04_range_filter #(.CLK_FREQ(1000000), .TIMEOUT_MS(2)) u_to (
    .clk(clk), .reset(reset), .in_valid(t_valid), .in_ticks(in_ticks),
    .out_valid(t_out_valid), .raw_cm(t_raw), .avg_cm(t_avg), .near(t_near), .fault(t_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; int raw; int avg; bit nr;} exp_t;
  exp_t exp_q[$];
  int   raw_hist[$];   // last three raw cm values
  int   avg_win[$];    // last 2^AVG_LOG2 values fed to the average
  bit   m_near = 1'b0;

  function automatic int model_cm(input int unsigned t);
    longint unsigned v;
    v = (64'(t) * 64'(K)) >> 24;
    return (v > 64'd400) ? 400 : int'(v);
  endfunction

  function automatic int median3(input int a, input int b, input int c);
    int x[3];
    int tmp;
    x[0] = a; x[1] = b; x[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (x[j] > x[j+1]) begin tmp = x[j]; x[j] = x[j+1]; x[j+1] = tmp; end
    return x[1];
  endfunction

  task automatic model_push(input int unsigned t, input int due);
    int   cm;
    int   fed;
    int   s;
    exp_t e;
    cm = model_cm(t);
    raw_hist.push_back(cm);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
`ifdef HC_SR04_MEDIAN3_EN
    fed = median3(raw_hist[raw_hist.size()-1],
                  (raw_hist.size() > 1) ? raw_hist[raw_hist.size()-2] : 0,
                  (raw_hist.size() > 2) ? raw_hist[raw_hist.size()-3] : 0);
`else
    fed = cm;
`endif
    avg_win.push_back(fed);
    if (avg_win.size() > 4) void'(avg_win.pop_front());
    s = 0;
    foreach (avg_win[i]) s += avg_win[i];
    if (s / 4 < 30)       m_near = 1'b1;
    else if (s / 4 >= 35) m_near = 1'b0;
    e.due = due; e.raw = cm; e.avg = s / 4; e.nr = m_near;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  bit   sb_en = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_valid_unexpected", int'(out_valid), 0);
        else begin
          mon_e = exp_q.pop_front();
          check("sb_latency", cyc, mon_e.due);
          check("sb_raw_cm", int'(raw_cm), mon_e.raw);
          check("sb_avg_cm", int'(avg_cm), mon_e.avg);
          check("sb_near", int'(near), int'(mon_e.nr));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("out_valid_missing", int'(out_valid), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned t);
    in_valid = 1'b1;
    in_ticks = t;
    if (sb_en) model_push(t, cyc + LAT);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    // Outputs already registered this cycle survive; anything later is discarded.
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    raw_hist.delete();
    avg_win.delete();
    m_near = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_raw_cm"}, int'(raw_cm), 0);
    check({tag, "_avg_cm"}, int'(avg_cm), 0);
    check({tag, "_near"}, int'(near), 0);
    check({tag, "_fault"}, int'(fault), 0);
  endtask

  typedef struct {bit rst; int unsigned ticks; int raw; int avg; bit nr;} vec_t;
  vec_t vt[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t;
    int          r;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_t_fault", int'(t_fault), 0);
    reset = 1'b0;

`ifndef HC_SR04_MEDIAN3_EN
    // Table-driven vectors: conversion, ramp-up, saturation, near hysteresis
    vt[0]  = '{1'b1, 32'd1000000,   171,  42, 1'b0};
    vt[1]  = '{1'b0, 32'd1000000,   171,  85, 1'b0};
    vt[2]  = '{1'b0, 32'd1000000,   171, 128, 1'b0};
    vt[3]  = '{1'b0, 32'd1000000,   171, 171, 1'b0};
    vt[4]  = '{1'b0, 32'hFFFF_FFFF, 400, 228, 1'b0};
    vt[5]  = '{1'b0, 32'd0,           0, 185, 1'b0};
    vt[6]  = '{1'b1, 32'd169200,     29,   7, 1'b1};
    vt[7]  = '{1'b0, 32'd169200,     29,  14, 1'b1};
    vt[8]  = '{1'b0, 32'd169200,     29,  21, 1'b1};
    vt[9]  = '{1'b0, 32'd169200,     29,  29, 1'b1};
    vt[10] = '{1'b0, 32'd268300,     46,  33, 1'b1};
    vt[11] = '{1'b0, 32'd221700,     38,  35, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rst) do_reset();
      send(vt[i].ticks);
      repeat (LAT - 2) tick();
      check($sformatf("vec%0d_early_valid", i), int'(out_valid), 0);
      tick();
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
      check($sformatf("vec%0d_raw_cm", i), int'(raw_cm), vt[i].raw);
      check($sformatf("vec%0d_avg_cm", i), int'(avg_cm), vt[i].avg);
      check($sformatf("vec%0d_near", i), int'(near), int'(vt[i].nr));
      repeat (10 - LAT) tick();
    end
`else
    // Median build: 100, 300, 100 cm; medians fed are 0, 100, 100
    do_reset();
    send(32'd583300);
    repeat (9) tick();
    send(32'd1750000);
    repeat (9) tick();
    send(32'd583300);
    repeat (LAT - 2) tick();
    check("med_early_valid", int'(out_valid), 0);
    tick();
    check("med_out_valid", int'(out_valid), 1);
    check("med_raw_cm", int'(raw_cm), 100);
    check("med_avg_cm", int'(avg_cm), 50);
    repeat (5) tick();
`endif

    // Randomised stream against the model, starting with back-to-back samples
    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom_range(0, 2400000));
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       t = $urandom_range(0, 400000);
        1:       t = $urandom_range(0, 2400000);
        2:       t = $urandom;
        default: t = $urandom_range(150000, 260000);
      endcase
      send(t);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (LAT + 2) tick();
    check("stream_drained", exp_q.size(), 0);

    // Reset while three samples are in flight
    for (int i = 0; i < 3; i++) send($urandom_range(100000, 2000000));
    do_reset();
    check_all_zero("midreset");
    repeat (8) tick();
    check_all_zero("midreset_after");
    check("midreset_drained", exp_q.size(), 0);
    sb_en = 1'b0;

    // Timeout fault on the short-timeout instance
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    repeat (TO_CYC - 1) tick();
    check("timeout_before", int'(t_fault), 0);
    tick();
    check("timeout_assert", int'(t_fault), 1);
    repeat (5) tick();
    check("timeout_hold", int'(t_fault), 1);
    t_valid = 1'b1;
    check("timeout_same_cycle", int'(t_fault), 1);
    tick();
    t_valid = 1'b0;
    check("timeout_clear", int'(t_fault), 0);

    // in_valid on the cycle the counter would reach the timeout
    repeat (TO_CYC - 1) tick();
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    check("timeout_coincide", int'(t_fault), 0);
    tick();
    check("timeout_coincide_next", int'(t_fault), 0);
    check("main_fault_quiet", int'(fault), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
